// File: rtl/carpma_birimi_pkg.sv
// carpma_birimi_pkg
//   Shared constants and decode helpers for the RV32M multiply unit.
//   - ISLEM_* : 2-bit operation codes (MUL, MULH, MULHSU, MULHU)
//   - VERI_BIT_VARSAYILAN / ETIKET_BIT_VARSAYILAN : default widths
//   - isaret_coz : operation -> operand signedness table
//   - ust_kelime : operation -> take high product word
package carpma_birimi_pkg;

  localparam int VERI_BIT_VARSAYILAN   = 32;
  localparam int ETIKET_BIT_VARSAYILAN = 4;

  localparam logic [1:0] ISLEM_MUL    = 2'b00;
  localparam logic [1:0] ISLEM_MULH   = 2'b01;
  localparam logic [1:0] ISLEM_MULHSU = 2'b10;
  localparam logic [1:0] ISLEM_MULHU  = 2'b11;

  typedef struct packed {
    logic islec0_isaretli;
    logic islec1_isaretli;
  } isaret_t;

  // MUL only keeps the low word, which is identical for any signedness,
  // so it is run unsigned like MULHU.
  function automatic isaret_t isaret_coz(input logic [1:0] islem);
    isaret_t sonuc;
    case (islem)
      ISLEM_MULH:   sonuc = '{islec0_isaretli: 1'b1, islec1_isaretli: 1'b1};
      ISLEM_MULHSU: sonuc = '{islec0_isaretli: 1'b1, islec1_isaretli: 1'b0};
      default:      sonuc = '{islec0_isaretli: 1'b0, islec1_isaretli: 1'b0};
    endcase
    return sonuc;
  endfunction

  function automatic logic ust_kelime(input logic [1:0] islem);
    return islem != ISLEM_MUL;
  endfunction

endpackage

// File: rtl/carpma_birimi_carpici.sv
// carpici
//   Combinational 32x32 -> 64 multiplier core with per-operand signedness.
//   Ports:
//     islec0, islec1                   : 32-bit operands
//     islec0_isaretli, islec1_isaretli : treat operand as two's complement
//     carpim                           : 64-bit product
module carpici (
  input  logic [31:0] islec0,
  input  logic [31:0] islec1,
  input  logic        islec0_isaretli,
  input  logic        islec1_isaretli,
  output logic [63:0] carpim
);

  logic [63:0] genis0;
  logic [63:0] genis1;

  // Extending both operands to 64 bits makes a plain 64-bit product exact
  // modulo 2^64 for every signedness combination.
  assign genis0 = {{32{islec0_isaretli & islec0[31]}}, islec0};
  assign genis1 = {{32{islec1_isaretli & islec1[31]}}, islec1};
  assign carpim = genis0 * genis1;

endmodule

// File: rtl/carpma_birimi.sv
// carpma_birimi
//   RV32M multiply execution unit: two-register pipeline (S1 operands,
//   S2 selected result) around the combinational carpici core.
//   Ports:
//     clk_i, rst_i                      : clock, async active-high reset
//     istek_gecerli_i / istek_hazir_o   : request handshake
//     islem_i, islec0_i, islec1_i       : operation and operands
//     etiket_i                          : request tag
//     temizle_i                         : flush all in-flight work
//     sonuc_gecerli_o / sonuc_hazir_i   : result handshake
//     sonuc_o, etiket_o                 : result word and its tag
//   Optional (macro CARPMA_SAYAC_EN):
//     tamamlanan_sayisi_o               : result transfers (wrapping)
//     durdurma_sayisi_o                 : cycles stalled by writeback
module carpma_birimi
  import carpma_birimi_pkg::*;
#(
  parameter int VERI_BIT   = VERI_BIT_VARSAYILAN,
  parameter int ETIKET_BIT = ETIKET_BIT_VARSAYILAN
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  istek_gecerli_i,
  output logic                  istek_hazir_o,
  input  logic [1:0]            islem_i,
  input  logic [VERI_BIT-1:0]   islec0_i,
  input  logic [VERI_BIT-1:0]   islec1_i,
  input  logic [ETIKET_BIT-1:0] etiket_i,
  input  logic                  temizle_i,
`ifdef CARPMA_SAYAC_EN
  output logic [31:0]           tamamlanan_sayisi_o,
  output logic [31:0]           durdurma_sayisi_o,
`endif
  output logic                  sonuc_gecerli_o,
  input  logic                  sonuc_hazir_i,
  output logic [VERI_BIT-1:0]   sonuc_o,
  output logic [ETIKET_BIT-1:0] etiket_o
);

  logic                  s1_v;
  logic [1:0]            s1_islem;
  logic [VERI_BIT-1:0]   s1_islec0;
  logic [VERI_BIT-1:0]   s1_islec1;
  logic [ETIKET_BIT-1:0] s1_etiket;

  logic                  s2_v;
  logic [VERI_BIT-1:0]   s2_sonuc;
  logic [ETIKET_BIT-1:0] s2_etiket;

  logic                  s2_ilerle;
  logic                  s1_ilerle;
  logic                  istek_al;
  isaret_t               isaret;
  logic [63:0]           carpim;
  logic [VERI_BIT-1:0]   secilen;

  assign s2_ilerle     = ~s2_v | sonuc_hazir_i;
  assign s1_ilerle     = s1_v & s2_ilerle;
  assign istek_hazir_o = ~rst_i & ~temizle_i & (~s1_v | s2_ilerle);
  assign istek_al      = istek_gecerli_i & istek_hazir_o;

  assign isaret = isaret_coz(s1_islem);

  carpici u_carpici (
    .islec0          (s1_islec0),
    .islec1          (s1_islec1),
    .islec0_isaretli (isaret.islec0_isaretli),
    .islec1_isaretli (isaret.islec1_isaretli),
    .carpim          (carpim)
  );

  assign secilen = ust_kelime(s1_islem) ? carpim[63:32] : carpim[31:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else if (temizle_i) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      if (istek_al) begin
        s1_v <= 1'b1;
      end else if (s1_ilerle) begin
        s1_v <= 1'b0;
      end
      if (s2_ilerle) begin
        s2_v <= s1_v;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_islem  <= ISLEM_MUL;
      s1_islec0 <= '0;
      s1_islec1 <= '0;
      s1_etiket <= '0;
    end else if (istek_al) begin
      s1_islem  <= islem_i;
      s1_islec0 <= islec0_i;
      s1_islec1 <= islec1_i;
      s1_etiket <= etiket_i;
    end
  end

  // A flushed S1 entry is dropped, so S2 data is not updated from it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s2_sonuc  <= '0;
      s2_etiket <= '0;
    end else if (s1_ilerle && !temizle_i) begin
      s2_sonuc  <= secilen;
      s2_etiket <= s1_etiket;
    end
  end

  assign sonuc_gecerli_o = s2_v;
  assign sonuc_o         = s2_sonuc;
  assign etiket_o        = s2_etiket;

`ifdef CARPMA_SAYAC_EN
  logic [31:0] tamamlanan_q;
  logic [31:0] durdurma_q;

  // Counters ignore temizle_i: a transfer in a flush cycle still counts.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tamamlanan_q <= '0;
      durdurma_q   <= '0;
    end else begin
      if (s2_v && sonuc_hazir_i) begin
        tamamlanan_q <= tamamlanan_q + 32'd1;
      end
      if (s2_v && !sonuc_hazir_i) begin
        durdurma_q <= durdurma_q + 32'd1;
      end
    end
  end

  assign tamamlanan_sayisi_o = tamamlanan_q;
  assign durdurma_sayisi_o   = durdurma_q;
`endif

endmodule
